// File: rtl/cla_word_sequencer.sv
// Operand sequencer that feeds a wide add, 5-bit word by word LSB first, through a registered CLA.
// Optional subtract mode (in_sub port) is enabled by defining CLA_SEQ_SUB_EN.
module cla_word_sequencer #(
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5*WORDS-1:0]   in_a,
  input  logic [5*WORDS-1:0]   in_b,
  input  logic                 in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                 in_sub,
`endif
  output logic [4:0]           cla_a,
  output logic [4:0]           cla_b,
  output logic                 cla_cin,
  input  logic [4:0]           cla_s,
  input  logic                 cla_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 busy
);
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [5*WORDS-1:0] a_q, b_q;
  logic               carry;
  logic [KW-1:0]      k;
  logic [CW-1:0]      cnt;
  logic               sub_in;
  logic               last_word;
  logic               accept;

`ifdef CLA_SEQ_SUB_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b0;
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign last_word = (k == KW'(WORDS - 1));

  // Word slices are driven straight from the captured operands, so they are
  // stable across ISSUE and WAIT and fall to zero everywhere else.
  assign cla_a   = busy ? a_q[5*k +: 5] : 5'd0;
  assign cla_b   = busy ? b_q[5*k +: 5] : 5'd0;
  assign cla_cin = busy ? carry : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (cnt == CW'(1)) state_nxt = last_word ? DONE : ISSUE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      k         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // Subtract folds into add: invert B once at capture, force carry-in to 1.
          a_q   <= in_a;
          b_q   <= sub_in ? ~in_b : in_b;
          carry <= sub_in ? 1'b1 : in_cin;
          k     <= '0;
        end
        ISSUE: cnt <= CW'(ADD_LAT);
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_sum[5*k +: 5] <= cla_s;
            carry             <= cla_cout;
            if (last_word) begin
              out_cout  <= cla_cout;
              out_valid <= 1'b1;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer with a behavioural two-stage registered 5-bit CLA attached.
module tb_cla_word_sequencer;
  localparam int W = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           in_cin;
  logic           in_sub;
  logic [4:0]     cla_a, cla_b, cla_s;
  logic           cla_cin, cla_cout;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_word_sequencer #(.WORDS(4), .ADD_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  // CLA: input register stage then output register stage.
  logic [4:0] ra, rb;
  logic       rc;
  always @(posedge clk) begin
    ra <= cla_a;
    rb <= cla_b;
    rc <= cla_cin;
    {cla_cout, cla_s} <= {1'b0, ra} + {1'b0, rb} + {5'd0, rc};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then lets the accepting edge pass.
  task automatic accept_req();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    step();
  endtask

  // Called right after the accepting edge; counts edges to out_valid.
  task automatic wait_result(input string tag, input logic chk_carry, output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
      if (!out_valid) begin
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
      end
      if (chk_carry && (n == 3 || n == 6 || n == 9))
        chk({tag, "_carry_chain"}, {31'd0, cla_cin}, 32'd1);
    end
    chk({tag, "_latency"}, n, 32'd12);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic [W-1:0] esum,
                        input logic ecout, input logic chk_carry);
    int n;
    in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1;
    accept_req();
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~c;   // post-acceptance changes must not matter
    wait_result(tag, chk_carry, n);
    chk({tag, "_sum"}, {12'd0, out_sum}, {12'd0, esum});
    chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ecout});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    step();   // out_ready assumed high: handshake
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cla_a", {27'd0, cla_a}, 32'd0);
    chk("rst_cla_cin", {31'd0, cla_cin}, 32'd0);
    chk("rst_out_sum", {12'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("carry_ripple", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b1);
    run_op("mixed_cin", 20'h12345, 20'h0ABCD, 1'b1, 1'b0, 20'h1CF13, 1'b0, 1'b0);

    // Backpressure in DONE.
    out_ready = 1'b0;
    in_a = 20'h00100; in_b = 20'h00200; in_cin = 1'b0; in_valid = 1'b1;
    accept_req();
    in_valid = 1'b0;
    wait_result("bp", 1'b0, n);
    held = out_sum;
    chk("bp_sum", {12'd0, out_sum}, 32'h00300);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_sum_hold", {12'd0, out_sum}, {12'd0, held});
      chk("bp_cout_hold", {31'd0, out_cout}, 32'd0);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_idle", {31'd0, in_ready}, 32'd1);

    // Back-to-back with in_valid held high.
    in_a = 20'h00003; in_b = 20'h00004; in_cin = 1'b0; in_valid = 1'b1;
    accept_req();
    in_a = 20'hFFFFF; in_b = 20'hFFFFF; in_cin = 1'b1;
    wait_result("b2b_0", 1'b0, n);
    chk("b2b_0_sum", {12'd0, out_sum}, 32'h00007);
    chk("b2b_0_cout", {31'd0, out_cout}, 32'd0);
    step();
    chk("b2b_idle", {31'd0, in_ready}, 32'd1);
    step();   // second request accepted on this edge
    in_valid = 1'b0;
    wait_result("b2b_1", 1'b0, n);
    chk("b2b_1_sum", {12'd0, out_sum}, 32'hFFFFF);
    chk("b2b_1_cout", {31'd0, out_cout}, 32'd1);
    step();

    // Reset during WAIT of word 2.
    in_a = 20'h12345; in_b = 20'h54321; in_cin = 1'b1; in_valid = 1'b1;
    accept_req();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_cla_a", {27'd0, cla_a}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("post_abort", 20'h00010, 20'h00020, 1'b0, 1'b0, 20'h00030, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_pos", 20'h00007, 20'h00005, 1'b0, 1'b1, 20'h00002, 1'b1, 1'b0);
    run_op("sub_neg", 20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
